// File: rtl/sensor_scan_pkg.sv
// sensor_scan_pkg: shared types and helpers for the sensor scan controller.
// Optional build macro SENSOR_SCAN_MASK_EN is handled in sensor_scan_ctrl.
package sensor_scan_pkg;

  localparam int BANK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  // Bits needed to hold 0..max_count without wrapping.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: per-bank saturating error counter with a sticky fault flag.
// clr wins over any sample on the same edge.
module sensor_debounce
  import sensor_scan_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sample_en,
  input  logic err,
  input  logic clr,
  output logic fault
);

  localparam int            CW      = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

  // Count consecutive erroring samples; latch fault when the count reaches DEBOUNCE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      fault <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      fault <= 1'b0;
    end else if (sample_en) begin
      if (err) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == CNT_MAX) begin
          fault <= 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin scan of NUM_BANKS sensor banks through one
// shared error decoder, with per-bank debounce, sticky faults and a 4-phase clear.
// Build macro SENSOR_SCAN_MASK_EN adds bank_mask to skip selected banks.
//
// state  | meaning
// IDLE   | waiting for scan_en, decoder input parked at 0
// DRIVE  | selected bank routed to the decoder, settle cycle
// SAMPLE | bank still routed, dec_error captured at the end of the cycle
// DONE   | one-cycle scan_done pulse, bank index back to 0
module sensor_scan_ctrl
  import sensor_scan_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int DEBOUNCE  = 3
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         scan_en,
  input  logic [BANK_W*NUM_BANKS-1:0]  sensor_banks,
`ifdef SENSOR_SCAN_MASK_EN
  input  logic [NUM_BANKS-1:0]         bank_mask,
`endif
  output logic [BANK_W-1:0]            dec_sensors,
  input  logic                         dec_error,
  output logic [$clog2(NUM_BANKS)-1:0] bank_idx,
  output logic [NUM_BANKS-1:0]         fault_vec,
  output logic                         alarm,
  output logic                         scan_done,
  input  logic                         clr_req,
  output logic                         clr_ack
);

  localparam int IW = $clog2(NUM_BANKS);

  scan_state_e       state_q, state_d;
  logic [IW-1:0]     bank_idx_q, bank_idx_d;
  logic [BANK_W-1:0] bank_arr [NUM_BANKS];
  logic [NUM_BANKS-1:0] mask_eff;
  logic [NUM_BANKS-1:0] bank_hit;
  logic [IW-1:0]     first_bank, next_bank;
  logic              first_found, next_found;
  logic              clr_pulse;

`ifdef SENSOR_SCAN_MASK_EN
  assign mask_eff = bank_mask;
`else
  assign mask_eff = '0;
`endif

  // A clear fires once per request: on the first edge req is seen with ack low.
  assign clr_pulse = clr_req & ~clr_ack;
  assign alarm     = |fault_vec;
  assign bank_idx  = bank_idx_q;

  // Lowest unmasked bank overall, and lowest unmasked bank above the current one.
  always_comb begin
    first_bank  = '0;
    first_found = 1'b0;
    next_bank   = '0;
    next_found  = 1'b0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (!mask_eff[i]) begin
        first_bank  = IW'(i);
        first_found = 1'b1;
        if (i > int'(bank_idx_q)) begin
          next_bank  = IW'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  // State and bank index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bank_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_idx_q <= bank_idx_d;
    end
  end

  // Next-state, next bank select and decoder/scan_done outputs.
  always_comb begin
    state_d     = state_q;
    bank_idx_d  = bank_idx_q;
    dec_sensors = '0;
    scan_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          if (first_found) begin
            state_d    = DRIVE;
            bank_idx_d = first_bank;
          end else begin
            state_d    = DONE;
            bank_idx_d = '0;
          end
        end
      end
      DRIVE: begin
        dec_sensors = bank_arr[bank_idx_q];
        state_d     = SAMPLE;
      end
      SAMPLE: begin
        dec_sensors = bank_arr[bank_idx_q];
        if (next_found) begin
          state_d    = DRIVE;
          bank_idx_d = next_bank;
        end else begin
          state_d    = DONE;
          bank_idx_d = '0;
        end
      end
      DONE: begin
        scan_done  = 1'b1;
        bank_idx_d = '0;
        if (scan_en) begin
          if (first_found) begin
            state_d    = DRIVE;
            bank_idx_d = first_bank;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        bank_idx_d = '0;
      end
    endcase
  end

  // Acknowledge register: set by a clear, dropped once req is seen low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clr_ack <= 1'b0;
    end else if (clr_pulse) begin
      clr_ack <= 1'b1;
    end else if (!clr_req) begin
      clr_ack <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_arr[g] = sensor_banks[g*BANK_W +: BANK_W];
    assign bank_hit[g] = (state_q == SAMPLE) && (bank_idx_q == IW'(g));

    sensor_debounce #(
      .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
      .clk       (clk),
      .n_rst     (n_rst),
      .sample_en (bank_hit[g]),
      .err       (dec_error),
      .clr       (clr_pulse | mask_eff[g]),
      .fault     (fault_vec[g])
    );
  end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: directed bench with a scan-schedule reference model.
// Mask tests run only when SENSOR_SCAN_MASK_EN is defined.
module tb_sensor_scan_ctrl;

  localparam int NB = 4;
  localparam int DB = 3;

  logic          clk;
  logic          n_rst;
  logic          scan_en;
  logic [4*NB-1:0] sensor_banks;
  logic [NB-1:0] mask_v;
  logic [3:0]    dec_sensors;
  logic          dec_error;
  logic [1:0]    bank_idx;
  logic [NB-1:0] fault_vec;
  logic          alarm;
  logic          scan_done;
  logic          clr_req;
  logic          clr_ack;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  sensor_scan_ctrl #(.NUM_BANKS(NB), .DEBOUNCE(DB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .scan_en      (scan_en),
    .sensor_banks (sensor_banks),
`ifdef SENSOR_SCAN_MASK_EN
    .bank_mask    (mask_v),
`endif
    .dec_sensors  (dec_sensors),
    .dec_error    (dec_error),
    .bank_idx     (bank_idx),
    .fault_vec    (fault_vec),
    .alarm        (alarm),
    .scan_done    (scan_done),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack)
  );

  // Behavioural decoder: any set sensor bit is an error.
  assign dec_error = |dec_sensors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A scan is a list of unmasked banks; position p walks 0..2*len,
  // odd positions are samples, p == 2*len is the done cycle.
  int            m_cnt [NB];
  logic [NB-1:0] m_fault;
  int            m_list [NB];
  int            m_len;
  bit            m_busy;
  int            m_pos;
  bit            m_ack;

  function automatic logic [3:0] bank_val(input int b);
    return sensor_banks[b*4 +: 4];
  endfunction

  function automatic int exp_idx();
    return (m_busy && m_pos < 2*m_len) ? m_list[m_pos/2] : 0;
  endfunction

  function automatic logic [3:0] exp_sens();
    return (m_busy && m_pos < 2*m_len) ? bank_val(exp_idx()) : 4'h0;
  endfunction

  function automatic bit exp_done();
    return m_busy && (m_pos == 2*m_len);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    m_fault = '0;
    m_len   = 0;
    m_busy  = 0;
    m_pos   = 0;
    m_ack   = 0;
  endtask

  task automatic build_list();
    m_len = 0;
    for (int i = 0; i < NB; i++) begin
      if (!mask_v[i]) begin
        m_list[m_len] = i;
        m_len++;
      end
    end
  endtask

  task automatic model_step();
    bit smp;
    bit clr;
    int sb;
    smp = m_busy && (m_pos < 2*m_len) && (m_pos % 2 == 1);
    sb  = smp ? m_list[m_pos/2] : 0;
    clr = clr_req && !m_ack;
    if (clr) begin
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      m_fault = '0;
    end else if (smp) begin
      if (bank_val(sb) != 4'h0) begin
        if (m_cnt[sb] < DB) m_cnt[sb]++;
        if (m_cnt[sb] == DB) m_fault[sb] = 1'b1;
      end else begin
        m_cnt[sb] = 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (mask_v[i]) begin
        m_cnt[i]   = 0;
        m_fault[i] = 1'b0;
      end
    end
    if (clr) m_ack = 1;
    else if (!clr_req) m_ack = 0;
    if (!m_busy || m_pos == 2*m_len) begin
      if (scan_en) begin
        build_list();
        m_busy = 1;
        m_pos  = 0;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && n_rst) begin
        check("bank_idx",    32'(bank_idx),    32'(exp_idx()));
        check("dec_sensors", 32'(dec_sensors), 32'(exp_sens()));
        check("scan_done",   32'(scan_done),   32'(exp_done()));
        check("fault_vec",   32'(fault_vec),   32'(m_fault));
        check("alarm",       32'(alarm),       32'(|m_fault));
        check("clr_ack",     32'(clr_ack),     32'(m_ack));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc();
      seen = scan_done;
    end
    check("scan_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bank_idx"},  32'(bank_idx),    32'd0);
    check({tag, "_dec"},       32'(dec_sensors), 32'd0);
    check({tag, "_fault_vec"}, 32'(fault_vec),   32'd0);
    check({tag, "_alarm"},     32'(alarm),       32'd0);
    check({tag, "_scan_done"}, 32'(scan_done),   32'd0);
    check({tag, "_clr_ack"},   32'(clr_ack),     32'd0);
  endtask

  initial begin
    logic [1:0] prev_idx;
    bit         hit;
    n_rst        = 1'b0;
    scan_en      = 1'b0;
    clr_req      = 1'b0;
    sensor_banks = '0;
    mask_v       = '0;

    // Reset state
    repeat (2) cyc();
    check_all_zero("in_reset");
    n_rst  = 1'b1;
    chk_en = 1;
    cyc();
    check_all_zero("post_reset");

    // Clean scan: bank sequence and scan_done in the 10th cycle
    scan_en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c <= 8) begin
        check("t1_bank_idx", 32'(bank_idx), 32'((c - 1) / 2));
        check("t1_no_done",  32'(scan_done), 32'd0);
      end else begin
        check("t1_done", 32'(scan_done), 32'd1);
        check("t1_bank_idx_done", 32'(bank_idx), 32'd0);
      end
    end
    check("t1_fault", 32'(fault_vec), 32'd0);
    check("t1_alarm", 32'(alarm), 32'd0);
    scan_en = 1'b0;
    cyc();
    cyc();

    // Bank 2 stuck erroring: fault after the third scan, not the second
    sensor_banks[11:8] = 4'b0001;
    scan_en = 1'b1;
    wait_done();
    wait_done();
    check("t2_fault_after2", 32'(fault_vec), 32'h0);
    wait_done();
    check("t2_fault_after3", 32'(fault_vec), 32'h4);
    check("t2_alarm", 32'(alarm), 32'd1);

    // Short clear
    sensor_banks = '0;
    clr_req = 1'b1;
    cyc();
    check("t2_clr_ack", 32'(clr_ack), 32'd1);
    check("t2_clr_fault", 32'(fault_vec), 32'h0);
    clr_req = 1'b0;
    cyc();
    check("t2_clr_ack_drop", 32'(clr_ack), 32'd0);

    // Bank 1: err, err, clean, err, err, err; bank 3 joins for the last three
    wait_done();
    sensor_banks[7:4] = 4'hA;
    wait_done();
    wait_done();
    check("t3_fault_after_2err", 32'(fault_vec), 32'h0);
    sensor_banks[7:4] = 4'h0;
    wait_done();
    sensor_banks[7:4]   = 4'h2;
    sensor_banks[15:12] = 4'hF;
    wait_done();
    wait_done();
    check("t3_fault_after_2more", 32'(fault_vec), 32'h0);
    wait_done();
    check("t3_fault_final", 32'(fault_vec), 32'hA);

    // Clear held for 3 cycles while banks keep erroring; bank 1 gets sampled
    // while req is still high, so a repeated clear would show up in the model
    cyc();
    cyc();
    clr_req = 1'b1;
    cyc();
    check("t4_ack_rise", 32'(clr_ack), 32'd1);
    check("t4_fault_clr", 32'(fault_vec), 32'h0);
    cyc();
    check("t4_ack_hold1", 32'(clr_ack), 32'd1);
    cyc();
    check("t4_ack_hold2", 32'(clr_ack), 32'd1);
    clr_req = 1'b0;
    cyc();
    check("t4_ack_drop", 32'(clr_ack), 32'd0);
    wait_done();
    wait_done();
    wait_done();
    check("t4_refault", 32'(fault_vec), 32'hA);

    // Async reset at bank 2 DRIVE
    sensor_banks = '0;
    sensor_banks[11:8] = 4'h8;
    prev_idx = bank_idx;
    hit = 0;
    for (int k = 0; k < 30 && !hit; k++) begin
      cyc();
      hit = (bank_idx == 2'd2) && (prev_idx != 2'd2);
      prev_idx = bank_idx;
    end
    check("t5_reached_bank2", 32'(hit), 32'd1);
    check("t5_dec_bank2", 32'(dec_sensors), 32'h8);
    #1 n_rst = 1'b0;
    #1 check_all_zero("t5_async");
    cyc();
    cyc();
    check_all_zero("t5_held");
    n_rst = 1'b1;
    cyc();
    check("t5_resume_idx", 32'(bank_idx), 32'd0);
    check("t5_resume_done", 32'(scan_done), 32'd0);
    cyc();
    cyc();
    check("t5_next_idx", 32'(bank_idx), 32'd1);
    scan_en = 1'b0;
    wait_done();
    cyc();

`ifdef SENSOR_SCAN_MASK_EN
    // Banks 1 and 2 masked: 0,0,3,3 then DONE in the 6th cycle
    mask_v  = 4'b0110;
    scan_en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c <= 4) begin
        check("m1_bank_idx", 32'(bank_idx), (c <= 2) ? 32'd0 : 32'd3);
        check("m1_no_done", 32'(scan_done), 32'd0);
      end else begin
        check("m1_done", 32'(scan_done), 32'd1);
      end
    end
    scan_en = 1'b0;
    cyc();
    // All masked: DONE in the 2nd cycle
    mask_v  = 4'b1111;
    scan_en = 1'b1;
    cyc();
    check("m2_done", 32'(scan_done), 32'd1);
    scan_en = 1'b0;
    cyc();
    mask_v = '0;
    cyc();
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_scan_ctrl.md
Name: sensor_scan_ctrl

Overview:
- Time-shares one external 4-bit sensor error decoder across NUM_BANKS sensor banks.
- Scans the banks round-robin: drives one bank onto the decoder, samples the decoder's error result, and debounces it per bank.
- Latches sticky per-bank faults and a summary alarm.
- A 4-phase clear handshake lets supervisory logic acknowledge and clear faults.

Parameters:
- NUM_BANKS, 4, number of 4-bit sensor banks scanned (2..16).
- DEBOUNCE, 3, consecutive erroring samples of a bank needed to latch its fault (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- scan_en  input  1  level; while high, scans repeat back-to-back.
- sensor_banks  input  4*NUM_BANKS  bank b occupies bits [4b+3:4b].
- dec_sensors  output  4  bank currently routed to the shared decoder.
- dec_error  input  1  combinational error result from the shared decoder for dec_sensors.
- bank_idx  output  clog2(NUM_BANKS)  index of the bank being driven.
- fault_vec  output  NUM_BANKS  sticky per-bank fault flags.
- alarm  output  1  OR of fault_vec.
- scan_done  output  1  one-cycle pulse at the end of each full scan.
- clr_req  input  1  4-phase clear request.
- clr_ack  output  1  clear acknowledge.

Behaviour:
- Reset values: all outputs 0, state IDLE, all debounce counters 0.
- State machine has four states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE: bank_idx=0, dec_sensors=0. If scan_en=1, go to DRIVE with bank 0.
  - DRIVE: dec_sensors=sensor_banks[bank_idx] from a registered mux select. This is one settle cycle. Next state is SAMPLE.
  - SAMPLE: dec_sensors is still driven. dec_error is captured at the end of this cycle. If bank_idx=NUM_BANKS-1, go to DONE; otherwise bank_idx+1 and go to DRIVE.
  - DONE: scan_done=1 for exactly this cycle; bank_idx returns to 0. If scan_en=1 go to DRIVE, else go to IDLE.
- Scan latency: 2*NUM_BANKS+1 cycles from the first DRIVE through DONE. That is 9 cycles at default, with scan_done in the 10th cycle after scan_en is first sampled high in IDLE.
- scan_en dropping mid-scan does not abort; the scan completes through DONE, then returns to IDLE.
- Debounce, per bank, on each SAMPLE of that bank:
  - dec_error=1: counter increments, saturating at DEBOUNCE. When the counter reaches DEBOUNCE, that bank's fault_vec bit is set the same edge.
  - dec_error=0: counter resets to 0. The fault bit is unaffected (sticky).
- Counter width is clog2(DEBOUNCE+1); no wrap is allowed.
- alarm = |fault_vec, combinational from the fault register.
- Clear handshake:
  - When clr_req=1 and clr_ack=0 at an edge, all fault bits and counters are cleared and clr_ack is set.
  - clr_ack stays high until clr_req is sampled low, then drops the next edge. No further clear occurs while clr_req stays high.
  - Clear has priority over a fault-set or counter increment on the same edge.
  - The clear does not disturb scan state.
- Reset mid-scan returns immediately to IDLE with all outputs 0.

Optional Feature:
- Macro: SENSOR_SCAN_MASK_EN.
- With the macro defined:
  - Adds input bank_mask [NUM_BANKS-1:0].
  - Masked banks are skipped: the scan never enters DRIVE for them, and bank_idx advances to the next unmasked bank.
  - A masked bank's counter and fault bit are held at 0.
  - All banks masked: IDLE with scan_en goes directly to DONE.
- Without the macro: no port, and every bank is scanned.

Decomposition:
- Package sensor_scan_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - a bank-width constant of 4;
  - a helper function for counter width.
- One sub-module, sensor_debounce, instantiated NUM_BANKS times. It contains the saturating counter plus sticky fault bit, with inputs sample_en, err, clr and output fault.

Test Plan:
- Reset then scan_en=1 with all banks 0000 and dec_error tied to a behavioural decoder: bank_idx sequence 0,0,1,1,2,2,3,3 over DRIVE/SAMPLE; scan_done pulses at cycle 10; fault_vec=0, alarm=0.
- Bank 2 = 0001 held with scan_en=1: fault_vec=0100 and alarm=1 after the third scan's bank-2 SAMPLE, not after the second.
- Bank 1 errors on 2 scans, is clean on 1 scan, then errors on 3 scans: fault sets only on the final 3rd consecutive sample.
- With fault_vec=1010, pulse clr_req high for 3 cycles: clr_ack high the cycle after req, fault_vec=0000 same edge; clr_ack drops one cycle after req drops; only one clear occurs.
- Assert n_rst low mid-scan at bank 2 DRIVE: all outputs 0 asynchronously; resume from IDLE with bank 0.
- With SENSOR_SCAN_MASK_EN and bank_mask=0110 at default NUM_BANKS: only banks 0 and 3 are driven, and scan_done arrives 6 cycles after scan_en. With bank_mask=1111: scan_done arrives 2 cycles after scan_en.
